// File: rtl/featuremap_pad_writer.sv
// Writes one channel's (WIDTH+2) x (HEIGHT+2) zero-padded frame into its feature-map FIFO.
// Define FMAP_WRITER_RELU_EN to clamp negative pixels (sign bit set) to +0.0 on the way through.
module featuremap_pad_writer #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           WIDTH      = 112,
  parameter int unsigned           HEIGHT     = 112,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  input  logic                  wr_full,
  output logic                  wrreq,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned   CW       = $clog2(WIDTH + 2);
  localparam int unsigned   RW       = $clog2(HEIGHT + 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAD   = 2'd1,
    ST_PIXEL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  wrreq_q, wrreq_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;

  logic                  issue_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  last_col_s;
  logic                  last_row_s;
  logic [RW-1:0]         next_row_s;
  logic [CW-1:0]         next_col_s;
  logic                  next_border_s;

  function automatic logic [DATA_WIDTH-1:0] pixel_fn(input logic [DATA_WIDTH-1:0] px);
`ifdef FMAP_WRITER_RELU_EN
    if (px[DATA_WIDTH-1]) begin
      pixel_fn = {DATA_WIDTH{1'b0}};
    end else begin
      pixel_fn = px;
    end
`else
    pixel_fn = px;
`endif
  endfunction

  assign ready_out  = (state_q == ST_PIXEL) && !wr_full;
  assign wrreq      = wrreq_q;
  assign data_out   = data_out_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Position that follows the current one in raster order, and whether it is a border word.
  always_comb begin
    last_col_s = (col_q == COL_LAST);
    last_row_s = (row_q == ROW_LAST);
    if (last_col_s) begin
      next_col_s = {CW{1'b0}};
      next_row_s = row_q + RW'(1'b1);
    end else begin
      next_col_s = col_q + CW'(1'b1);
      next_row_s = row_q;
    end
    next_border_s = (next_row_s == {RW{1'b0}}) || (next_row_s == ROW_LAST) ||
                    (next_col_s == {CW{1'b0}}) || (next_col_s == COL_LAST);
  end

  // Next-state, position and write-port decode.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    wrreq_d      = 1'b0;
    data_out_d   = data_out_q;
    frame_done_d = 1'b0;
    issue_s      = 1'b0;
    word_s       = PAD_VALUE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PAD;
          row_d   = {RW{1'b0}};
          col_d   = {CW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAD: begin
        issue_s = !wr_full;
        word_s  = PAD_VALUE;
      end
      ST_PIXEL: begin
        issue_s = valid_in && !wr_full;
        word_s  = pixel_fn(data_in);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every issued word advances the position; the word class is re-derived from where we land.
    if (issue_s) begin
      wrreq_d    = 1'b1;
      data_out_d = word_s;
      if (last_col_s && last_row_s) begin
        state_d      = ST_DONE;
        frame_done_d = 1'b1;
        row_d        = {RW{1'b0}};
        col_d        = {CW{1'b0}};
      end else begin
        row_d = next_row_s;
        col_d = next_col_s;
        if (next_border_s) begin
          state_d = ST_PAD;
        end else begin
          state_d = ST_PIXEL;
        end
      end
    end else begin
      wrreq_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, position and registered FIFO-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= {RW{1'b0}};
      col_q        <= {CW{1'b0}};
      wrreq_q      <= 1'b0;
      data_out_q   <= {DATA_WIDTH{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wrreq_q      <= wrreq_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Bench for featuremap_pad_writer (WIDTH=4, HEIGHT=3): position-index model checked every cycle,
// plus whole-frame checks against the padded-frame layout and a few literal words.
module tb_featuremap_pad_writer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NW = (W + 2) * (H + 2);
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_out;
  logic        wr_full;
  logic        wrreq;
  logic [31:0] data_out;
  logic        busy;
  logic        frame_done;

  always #5 clk = ~clk;

  featuremap_pad_writer #(
    .DATA_WIDTH(32),
    .WIDTH     (W),
    .HEIGHT    (H),
    .PAD_VALUE (32'h00000000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .wr_full   (wr_full),
    .wrreq     (wrreq),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] vals [NP];
  logic [31:0] got [$];
  int          fd_idx;
  int          rdy_cnt;

  // Model: phase 0 idle, 1 writing positions, 2 done cycle; m_pos = next raster position.
  int          m_phase = 0;
  int          m_pos   = 0;
  logic        m_wr    = 1'b0;
  logic        m_fd    = 1'b0;
  logic [31:0] m_data  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef FMAP_WRITER_RELU_EN
    return x[31] ? 32'h00000000 : x;
`else
    return x;
`endif
  endfunction

  function automatic bit interior(input int idx);
    int r;
    int c;
    r = idx / (W + 2);
    c = idx % (W + 2);
    return (r >= 1) && (r <= H) && (c >= 1) && (c <= W);
  endfunction

  function automatic logic [31:0] frame_word(input int idx);
    int r;
    int c;
    r = idx / (W + 2);
    c = idx % (W + 2);
    if (interior(idx)) return relu(vals[(r - 1) * W + (c - 1)]);
    return 32'h00000000;
  endfunction

  // Per-cycle compare at the falling edge, then advance the model with the inputs the DUT will see.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = 0; m_pos = 0; m_wr = 1'b0; m_fd = 1'b0; m_data = 32'h0;
        chk("rst_data_out", data_out, 32'h0);
      end
      chk("wrreq", {31'b0, wrreq}, {31'b0, m_wr});
      if (m_wr) chk("data_out", data_out, m_data);
      chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
      chk("busy", {31'b0, busy}, {31'b0, (m_phase != 0)});
      chk("ready_out", {31'b0, ready_out},
          {31'b0, (m_phase == 1) && interior(m_pos) && !wr_full});
      if (wrreq) begin
        got.push_back(data_out);
        if (frame_done) fd_idx = got.size() - 1;
      end
      if (ready_out) rdy_cnt++;
      m_wr = 1'b0;
      m_fd = 1'b0;
      if (!rst) begin
        if (m_phase == 0) begin
          if (start) begin m_phase = 1; m_pos = 0; end
        end else if (m_phase == 1) begin
          if (!wr_full && (!interior(m_pos) || valid_in)) begin
            m_wr   = 1'b1;
            m_data = interior(m_pos) ? relu(data_in) : 32'h00000000;
            m_pos++;
            if (m_pos == NW) begin m_phase = 2; m_fd = 1'b1; end
          end
        end else begin
          m_phase = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0 plain, 1 wr_full stall in row 2, 2 valid toggling, 3 start pulses while busy/done, 4 stop at word 10
  task automatic run_frame(input int mode);
    int   p = 0;
    int   cyc = 0;
    int   stall_left = 5;
    bit   pulsed = 0;
    bit   finished = 0;
    logic acc;
    got.delete();
    rdy_cnt = 0;
    fd_idx  = -1;
    start    = 1'b1;
    valid_in = 1'b1;
    data_in  = vals[0];
    wr_full  = 1'b0;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      acc = valid_in && ready_out;
      tick();
      cyc++;
      start = 1'b0;
      if (acc) p++;
      wr_full = 1'b0;
      if (mode == 1 && stall_left > 0 && got.size() >= 14) begin
        wr_full = 1'b1;
        stall_left--;
      end
      valid_in = (p < NP) && (mode != 2 || (cyc % 2) == 0);
      data_in  = (p < NP) ? vals[p] : 32'h0;
      if (mode == 3 && !pulsed && got.size() == 5) begin start = 1'b1; pulsed = 1; end
      if (mode == 3 && frame_done) start = 1'b1;
      if (mode == 4 && got.size() >= 11) begin
        rst = 1'b1;
        #1;
        chk("rst_wrreq_now", {31'b0, wrreq}, 32'h0);
        chk("rst_busy_now", {31'b0, busy}, 32'h0);
        finished = 1;
      end else if (got.size() == NW && !busy && !frame_done) begin
        finished = 1;
      end
    end
    valid_in = 1'b0;
    start    = 1'b0;
    wr_full  = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: mode %0d words %0d expected %0d", mode, got.size(), NW);
    end
  endtask

  task automatic check_frame(input string name);
    chk({name, "_len"}, got.size(), NW);
    chk({name, "_done_idx"}, fd_idx, NW - 1);
    for (int i = 0; i < NW && i < got.size(); i++) chk({name, "_word"}, got[i], frame_word(i));
  endtask

  task automatic load_ramp();
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; wr_full = 1'b0; data_in = 32'h0;
    load_ramp();
    repeat (3) tick();
    chk("reset_ready", {31'b0, ready_out}, 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // Unstalled frame with literal pins on the padded layout
    run_frame(0);
    check_frame("plain");
    if (got.size() == NW) begin
      for (int i = 0; i < 7; i++) chk("plain_top_pad", got[i], 32'h00000000);
      chk("plain_word7", got[7], 32'h3F800000);
      chk("plain_word8", got[8], 32'h40000000);
      chk("plain_word16", got[16], 32'h41000000);
      chk("plain_word29", got[29], 32'h00000000);
    end
    chk("plain_ready_cycles", rdy_cnt, NP);
    repeat (2) tick();

    run_frame(1);
    check_frame("stall");
    chk("stall_ready_cycles", rdy_cnt, NP);
    repeat (2) tick();

    run_frame(2);
    check_frame("toggle");
    repeat (2) tick();

    // Abandon mid-frame, then a full frame from row 0
    run_frame(4);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    run_frame(0);
    check_frame("after_reset");
    if (got.size() == NW) chk("after_reset_word0", got[0], 32'h00000000);
    repeat (2) tick();

    // start during busy and in the done cycle is ignored
    run_frame(3);
    check_frame("start_ignored");
    repeat (4) tick();
    chk("idle_after_done_start", {31'b0, busy}, 32'h0);
    run_frame(0);
    check_frame("next_frame");
    if (got.size() == NW) chk("next_frame_word0", got[0], 32'h00000000);
    repeat (2) tick();

    // Signed pixels: -2.5, 3.0, -0.0
    vals[0] = 32'hC0200000;
    vals[1] = 32'h40400000;
    vals[2] = 32'h80000000;
    run_frame(0);
    check_frame("signed");
    if (got.size() == NW) begin
`ifdef FMAP_WRITER_RELU_EN
      chk("signed_neg", got[7], 32'h00000000);
      chk("signed_negzero", got[9], 32'h00000000);
`else
      chk("signed_neg", got[7], 32'hC0200000);
      chk("signed_negzero", got[9], 32'h80000000);
`endif
      chk("signed_pos", got[8], 32'h40400000);
    end
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
